// File: rtl/mv_tile_sequencer.sv
// Walks a tiled weight matrix through the combinational MV core, accumulating
// column-tile partial sums per lane and emitting one saturated result per row tile.

module mv_tile_lane #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          add,
    input  logic [DW-1:0] c,
    output logic [DW-1:0] sat
);
    localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;

    assign sum = acc + {{(AW-DW){c[DW-1]}}, c};

    // Saturate the running sum including this cycle's partial product, so the
    // last column tile's contribution lands in the result without an extra cycle.
    always_comb begin
        sat = sum[DW-1:0];
        if (sum > MAXV)
            sat = MAXV[DW-1:0];
        else if (sum < MINV)
            sat = MINV[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (add)
            acc <= sum;
    end
endmodule

module mv_tile_sequencer #(
    parameter int X           = 6,
    parameter int H           = 6,
    parameter int DATA_WIDTH  = 8,
    parameter int N_ROW_TILES = 2,
    parameter int N_COL_TILES = 2,
    parameter int ADDR_W      = 4,
    localparam int RW = (N_ROW_TILES > 1) ? $clog2(N_ROW_TILES) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [N_COL_TILES*X*DATA_WIDTH-1:0]   x_in,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  w_rd_en,
    output logic [ADDR_W-1:0]                     w_addr,
    input  logic [X*H*DATA_WIDTH-1:0]             w_rdata,
    output logic [X*H*DATA_WIDTH-1:0]             core_a,
    output logic [X*DATA_WIDTH-1:0]               core_b,
    input  logic [H*DATA_WIDTH-1:0]               core_c,
    output logic                                  y_valid,
    input  logic                                  y_ready,
    output logic [H*DATA_WIDTH-1:0]               y_data,
    output logic [RW-1:0]                         y_row_idx
);
    localparam int CW = (N_COL_TILES > 1) ? $clog2(N_COL_TILES) : 1;
    localparam int AW = DATA_WIDTH + $clog2(N_COL_TILES) + 1;
    localparam int TW = X * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MULT,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [RW-1:0]                 row_tile;
    logic [CW-1:0]                 col_tile;
    logic [N_COL_TILES*TW-1:0]     x_lat;
    logic [H-1:0][DATA_WIDTH-1:0]  c_lane;
    logic [H-1:0][DATA_WIDTH-1:0]  sat_lane;
    logic [H-1:0][DATA_WIDTH-1:0]  y_reg;
    logic                          last_col;
    logic                          last_row;
    logic                          accept;
    logic                          lane_clr;
    logic                          lane_add;

    assign last_col = (col_tile == CW'(N_COL_TILES - 1));
    assign last_row = (row_tile == RW'(N_ROW_TILES - 1));
    assign accept   = (state == S_OUT) && y_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_MULT;
            S_MULT:  state_nxt = last_col ? S_OUT : S_FETCH;
            S_OUT:   if (y_ready) state_nxt = last_row ? S_DONE : S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        w_rd_en = (state == S_FETCH);
        y_valid = (state == S_OUT);
        core_a  = '0;
        core_b  = '0;
        if (state == S_MULT) begin
            core_a = w_rdata;
            core_b = x_lat[(N_COL_TILES - 1 - int'(col_tile)) * TW +: TW];
        end
    end

    assign w_addr    = ADDR_W'(int'(row_tile) * N_COL_TILES + int'(col_tile));
    assign y_data    = y_reg;
    assign c_lane    = core_c;

    // Accumulators restart at pass start and at each row-tile handoff.
    assign lane_clr = ((state == S_IDLE) && start) || (accept && !last_row);
    assign lane_add = (state == S_MULT);

    genvar h;
    generate
        for (h = 0; h < H; h++) begin : g_lane
            mv_tile_lane #(
                .DW (DATA_WIDTH),
                .AW (AW)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (lane_clr),
                .add   (lane_add),
                .c     (c_lane[h]),
                .sat   (sat_lane[h])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            row_tile  <= '0;
            col_tile  <= '0;
            x_lat     <= '0;
            y_reg     <= '0;
            y_row_idx <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_lat    <= x_in;
                        row_tile <= '0;
                        col_tile <= '0;
                    end
                end
                S_MULT: begin
                    col_tile <= last_col ? '0 : col_tile + CW'(1);
                    if (last_col) begin
                        y_reg     <= sat_lane;
                        y_row_idx <= row_tile;
                    end
                end
                S_OUT: begin
                    if (y_ready)
                        row_tile <= last_row ? '0 : row_tile + RW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mv_tile_sequencer.sv
// Directed bench for mv_tile_sequencer with a stub core whose lanes return
// a programmable value per column tile.

module tb_mv_tile_sequencer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [95:0]  x_in;
    logic         busy, done, w_rd_en, y_valid, y_ready;
    logic [3:0]   w_addr;
    logic [287:0] w_rdata = '0;
    logic [287:0] core_a;
    logic [47:0]  core_b;
    logic [47:0]  core_c;
    logic [47:0]  y_data;
    logic [0:0]   y_row_idx;
    logic [7:0]   stub0, stub1;

    int ncmp = 0;
    int nerr = 0;
    int addr_q[$];
    logic [47:0] y_q[$];
    int row_q[$];
    int done_cnt = 0;

    mv_tile_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
        .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_addr(w_addr),
        .w_rdata(w_rdata), .core_a(core_a), .core_b(core_b), .core_c(core_c),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_row_idx(y_row_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [287:0] tile(input logic [3:0] a);
        logic [7:0] b;
        b = 8'h11 * {4'h0, a + 4'd1};
        return {36{b}};
    endfunction

    always @(posedge clk) if (w_rd_en) w_rdata <= tile(w_addr);

    // w_addr holds row*2+col through MULT, so bit 0 selects the column tile
    assign core_c = {6{w_addr[0] ? stub1 : stub0}};

    always @(negedge clk) begin
        if (rst_n) begin
            if (w_rd_en) addr_q.push_back(int'(w_addr));
            if (y_valid && y_ready) begin
                y_q.push_back(y_data);
                row_q.push_back(int'(y_row_idx));
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Runs one pass from an idle DUT and checks addresses, results and done.
    task automatic run_pass(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] lane, input int pulse_at);
        int a0, y0, d0, n, vl;
        a0 = addr_q.size(); y0 = y_q.size(); d0 = done_cnt;
        stub0 = s0; stub1 = s1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; vl = -1;
        while (!done && n < 40) begin
            if (n == pulse_at) start = 1'b1;
            else start = 1'b0;
            tick();
            n++;
            if (y_valid && vl < 0) vl = n;
        end
        start = 1'b0;
        check({tag, "_done_lat"}, 288'(n), 288'd10);
        if (y_ready) check({tag, "_yv_lat"}, 288'(vl), 288'd4);
        tick(); tick();
        check({tag, "_idle"}, 288'(busy), 288'd0);
        check({tag, "_done_cnt"}, 288'(done_cnt - d0), 288'd1);
        check({tag, "_naddr"}, 288'(addr_q.size() - a0), 288'd4);
        for (int i = 0; i < 4; i++)
            if (a0 + i < addr_q.size())
                check({tag, "_addr"}, 288'(addr_q[a0 + i]), 288'(i));
        check({tag, "_ny"}, 288'(y_q.size() - y0), 288'd2);
        for (int i = 0; i < 2; i++)
            if (y0 + i < y_q.size()) begin
                check({tag, "_ydata"}, 288'(y_q[y0 + i]), 288'({6{lane}}));
                check({tag, "_yrow"}, 288'(row_q[y0 + i]), 288'(i));
            end
    endtask

    initial begin
        logic [47:0] held;
        int n;
        rst_n = 1'b0; start = 1'b0; y_ready = 1'b1;
        x_in = 96'h0102030405060708090a0b0c;
        stub0 = 8'd0; stub1 = 8'd0;
        tick(); tick();
        check("rst_busy", 288'(busy), 288'd0);
        check("rst_done", 288'(done), 288'd0);
        check("rst_rden", 288'(w_rd_en), 288'd0);
        check("rst_yv", 288'(y_valid), 288'd0);
        check("rst_ydata", 288'(y_data), 288'd0);
        check("rst_addr", 288'(w_addr), 288'd0);
        check("rst_core_a", core_a, 288'd0);
        check("rst_core_b", 288'(core_b), 288'd0);
        rst_n = 1'b1;
        tick();

        // Core-side drive: x slices latched at start, tile data passed in MULT
        stub0 = 8'd10; stub1 = 8'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        x_in = '0;
        check("fetch_rden", 288'(w_rd_en), 288'd1);
        check("fetch_addr", 288'(w_addr), 288'd0);
        check("fetch_core_b", 288'(core_b), 288'd0);
        tick();
        check("mult0_rden", 288'(w_rd_en), 288'd0);
        check("mult0_core_a", core_a, tile(4'd0));
        check("mult0_core_b", 288'(core_b), 288'h010203040506);
        tick(); tick();
        check("mult1_core_a", core_a, tile(4'd1));
        check("mult1_core_b", 288'(core_b), 288'h0708090a0b0c);
        n = 0;
        while (!done && n < 40) begin tick(); n++; end
        tick(); tick();
        x_in = 96'h0102030405060708090a0b0c;

        run_pass("p10", 8'd10, 8'd10, 8'd20, -1);
        run_pass("sat_pos", 8'd100, 8'd100, 8'h7f, -1);
        run_pass("sat_neg", 8'h9c, 8'h9c, 8'h80, -1);
        run_pass("alt", 8'd5, 8'hfd, 8'd2, -1);
        run_pass("restart_ign", 8'd10, 8'd10, 8'd20, 2);

        // Backpressure at first OUT
        begin
            int a0, d0;
            a0 = addr_q.size(); d0 = done_cnt;
            stub0 = 8'd10; stub1 = 8'd10; y_ready = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (!y_valid && n < 20) begin tick(); n++; end
            check("bp_yv_lat", 288'(n), 288'd4);
            held = y_data;
            check("bp_ydata", 288'(held), 288'({6{8'd20}}));
            for (int i = 0; i < 5; i++) begin
                tick();
                check("bp_yv_held", 288'(y_valid), 288'd1);
                check("bp_ydata_stable", 288'(y_data), 288'(held));
                check("bp_no_fetch", 288'(w_rd_en), 288'd0);
            end
            y_ready = 1'b1;
            n = 0;
            while (!done && n < 40) begin tick(); n++; end
            check("bp_done_lat", 288'(n), 288'd6);
            tick(); tick();
            check("bp_naddr", 288'(addr_q.size() - a0), 288'd4);
            check("bp_done_cnt", 288'(done_cnt - d0), 288'd1);
        end

        // Reset during the second MULT aborts the pass
        begin
            int a0, y0, d0;
            a0 = addr_q.size(); y0 = y_q.size(); d0 = done_cnt;
            start = 1'b1;
            tick();
            start = 1'b0;
            tick(); tick(); tick();
            check("abort_in_mult1", 288'(w_addr), 288'd1);
            rst_n = 1'b0;
            tick();
            check("abort_busy", 288'(busy), 288'd0);
            check("abort_yv", 288'(y_valid), 288'd0);
            rst_n = 1'b1;
            tick(); tick(); tick();
            check("abort_no_done", 288'(done_cnt - d0), 288'd0);
            check("abort_no_y", 288'(y_q.size() - y0), 288'd0);
            check("abort_naddr", 288'(addr_q.size() - a0), 288'd2);
        end
        run_pass("after_abort", 8'd10, 8'd10, 8'd20, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
